// File: rtl/pio_osr_pkg.sv
// Shared types and sizes for the OSR pull controller and its count tracker.
package pio_osr_pkg;
  localparam int OSR_BITS  = 32;
  localparam int OSR_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_OUT     = 2'd1,
    OP_PULL    = 2'd2,
    OP_MOV_OSR = 2'd3
  } osr_op_t;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STALL_OUT  = 2'd1,
    S_STALL_PULL = 2'd2
  } osr_ctl_state_t;
endpackage

// File: rtl/osr_pull_controller_if.sv
// Decoder/FIFO-facing bundle of the OSR pull controller; slave is the controller.
interface osr_pull_controller_if;
  import pio_osr_pkg::*;

  logic                 en;
  logic                 instr_valid;
  osr_op_t              op;
  logic                 pull_block;
  logic                 pull_ifempty;
  logic [4:0]           out_count;
  logic                 autopull;
  logic [4:0]           pull_thresh;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 osr_pull;
  logic                 osr_shift_en;
  logic                 osr_autopull;
  logic                 osr_mov_x;
  logic                 stall;
  logic [OSR_CNT_W-1:0] osr_count;
  logic [15:0]          stall_cycles;
  osr_ctl_state_t       state;

  // Strobes and stall are Mealy outputs valid in the same cycle as the
  // instruction; a stalled instruction is re-presented unchanged until it completes.
  modport master (
    output en, instr_valid, op, pull_block, pull_ifempty, out_count,
           autopull, pull_thresh, fifo_empty,
    input  fifo_pop, osr_pull, osr_shift_en, osr_autopull, osr_mov_x,
           stall, osr_count, stall_cycles, state
  );

  modport slave (
    input  en, instr_valid, op, pull_block, pull_ifempty, out_count,
           autopull, pull_thresh, fifo_empty,
    output fifo_pop, osr_pull, osr_shift_en, osr_autopull, osr_mov_x,
           stall, osr_count, stall_cycles, state
  );
endinterface

// File: rtl/osr_count_tracker.sv
// Shadow OSR shift count with the 0-means-32 decodes, saturating add and threshold compares.
module osr_count_tracker
  import pio_osr_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_ld_sum,
  input  logic [4:0]           i_out_count,
  input  logic [4:0]           i_pull_thresh,
  output logic [OSR_CNT_W-1:0] o_count,
  output logic                 o_cnt_ge_thr,
  output logic                 o_sum_ge_thr
);
  logic [OSR_CNT_W-1:0] r_count;
  logic [OSR_CNT_W-1:0] w_thr;
  logic [OSR_CNT_W-1:0] w_n;
  logic [OSR_CNT_W-1:0] w_sum;
  logic [6:0]           w_sum_raw;

  assign w_thr     = (i_pull_thresh == 5'd0) ? OSR_CNT_W'(OSR_BITS) : {1'b0, i_pull_thresh};
  assign w_n       = (i_out_count == 5'd0) ? OSR_CNT_W'(OSR_BITS) : {1'b0, i_out_count};
  assign w_sum_raw = 7'(r_count) + 7'(w_n);
  assign w_sum     = (w_sum_raw > 7'(OSR_BITS)) ? OSR_CNT_W'(OSR_BITS) : w_sum_raw[OSR_CNT_W-1:0];

  assign o_count      = r_count;
  assign o_cnt_ge_thr = (r_count >= w_thr);
  assign o_sum_ge_thr = (w_sum >= w_thr);

  // An empty OSR (count 32) after reset makes the first autopull fire at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= OSR_CNT_W'(OSR_BITS);
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_ld_sum) begin
      r_count <= w_sum;
    end
  end
endmodule

// File: rtl/osr_pull_controller.sv
// Sequences OUT/PULL/MOV-to-OSR against the TX FIFO: strobes, pops, autopull and PC stall.
module osr_pull_controller
  import pio_osr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  osr_pull_controller_if.slave  bus
);
  osr_ctl_state_t       r_state;
  osr_ctl_state_t       w_next_state;
  logic [15:0]          r_stall_cycles;
  logic [OSR_CNT_W-1:0] w_count;
  logic                 w_cnt_ge_thr;
  logic                 w_sum_ge_thr;
  logic                 w_clr;
  logic                 w_ld_sum;
  logic                 w_pop;
  logic                 w_pull;
  logic                 w_shift;
  logic                 w_mov_x;
  logic                 w_stall;
  logic                 w_is_out;
  logic                 w_is_pull;
  logic                 w_is_mov;

  osr_count_tracker u_count (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clr         (w_clr),
    .i_ld_sum      (w_ld_sum),
    .i_out_count   (bus.out_count),
    .i_pull_thresh (bus.pull_thresh),
    .o_count       (w_count),
    .o_cnt_ge_thr  (w_cnt_ge_thr),
    .o_sum_ge_thr  (w_sum_ge_thr)
  );

  assign w_is_out  = bus.instr_valid && (bus.op == OP_OUT);
  assign w_is_pull = bus.instr_valid && (bus.op == OP_PULL);
  assign w_is_mov  = bus.instr_valid && (bus.op == OP_MOV_OSR);

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_ld_sum     = 1'b0;
    w_pop        = 1'b0;
    w_pull       = 1'b0;
    w_shift      = 1'b0;
    w_mov_x      = 1'b0;
    w_stall      = 1'b0;
    if (!rst && bus.en) begin
      if (w_is_out) begin
        if (bus.autopull && w_cnt_ge_thr) begin
          // Refill first; the shift happens when the instruction is re-presented.
          w_stall      = 1'b1;
          w_next_state = S_STALL_OUT;
          if (!bus.fifo_empty) begin
            w_pull = 1'b1;
            w_pop  = 1'b1;
            w_clr  = 1'b1;
          end
        end else begin
          w_shift      = 1'b1;
          w_next_state = S_IDLE;
          if (bus.autopull && w_sum_ge_thr && !bus.fifo_empty) begin
            w_pop = 1'b1;
            w_clr = 1'b1;
          end else begin
            w_ld_sum = 1'b1;
          end
        end
      end else if (w_is_pull) begin
        w_next_state = S_IDLE;
        if (bus.pull_ifempty && !w_cnt_ge_thr) begin
          w_clr = 1'b0;
        end else if (!bus.fifo_empty) begin
          w_pull = 1'b1;
          w_pop  = 1'b1;
          w_clr  = 1'b1;
        end else if (bus.pull_block) begin
          w_stall      = 1'b1;
          w_next_state = S_STALL_PULL;
        end else begin
          w_mov_x = 1'b1;
          w_clr   = 1'b1;
        end
      end else if (w_is_mov) begin
        w_next_state = S_IDLE;
        w_clr        = 1'b1;
      end else begin
        // No OSR instruction in execute: a dropped or changed stall is abandoned.
        w_next_state = S_IDLE;
        if (bus.autopull && w_cnt_ge_thr && !bus.fifo_empty) begin
          w_pull = 1'b1;
          w_pop  = 1'b1;
          w_clr  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (bus.en) begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.fifo_pop     = w_pop;
  assign bus.osr_pull     = w_pull;
  assign bus.osr_shift_en = w_shift;
  assign bus.osr_mov_x    = w_mov_x;
  assign bus.stall        = w_stall;
  assign bus.osr_autopull = ~rst & bus.autopull & ~bus.fifo_empty;
  assign bus.osr_count    = w_count;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_osr_pull_controller.sv
// Directed bench for osr_pull_controller with an expected-result queue.
module tb_osr_pull_controller;
  import pio_osr_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Entry = {fifo_pop, osr_pull, osr_shift_en, osr_mov_x, stall, osr_count after edge}.
  logic [10:0] exp_q[$];

  localparam logic [4:0] S_NONE   = 5'b00000;
  localparam logic [4:0] S_PULLP  = 5'b11000;
  localparam logic [4:0] S_REFILL = 5'b11001;
  localparam logic [4:0] S_SHIFT  = 5'b00100;
  localparam logic [4:0] S_SHPOP  = 5'b10100;
  localparam logic [4:0] S_STALL  = 5'b00001;
  localparam logic [4:0] S_MOVX   = 5'b00010;

  osr_pull_controller_if ifc ();

  osr_pull_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check strobes mid-cycle and the count after the edge.
  task automatic step(input string tag, input logic v, input osr_op_t o, input logic [4:0] oc,
                      input logic emp, input logic [4:0] exp_s, input logic [5:0] exp_c);
    logic [10:0] e;
    logic [4:0]  obs_s;
    @(negedge clk);
    ifc.instr_valid = v;
    ifc.op          = o;
    ifc.out_count   = oc;
    ifc.fifo_empty  = emp;
    exp_q.push_back({exp_s, exp_c});
    #1;
    e     = exp_q.pop_front();
    obs_s = {ifc.fifo_pop, ifc.osr_pull, ifc.osr_shift_en, ifc.osr_mov_x, ifc.stall};
    chk({tag, "_strobes"}, 32'(obs_s), 32'(e[10:6]));
    @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(ifc.osr_count), 32'(e[5:0]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.en = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.op = OP_NONE;
    ifc.pull_block = 1'b0;
    ifc.pull_ifempty = 1'b0;
    ifc.out_count = 5'd0;
    ifc.autopull = 1'b1;
    ifc.pull_thresh = 5'd0;
    ifc.fifo_empty = 1'b0;

    // Reset: strobes suppressed even though a background pull would qualify.
    step("rst0", 1'b0, OP_NONE, 5'd0, 1'b0, S_NONE, 6'd32);
    step("rst1", 1'b0, OP_NONE, 5'd0, 1'b0, S_NONE, 6'd32);
    chk("rst_stall_cycles", 32'(ifc.stall_cycles), 32'd0);
    chk("rst_state", 32'(ifc.state), 32'(S_IDLE));
    rst = 1'b0;

    // Background refill from an empty OSR.
    step("bg", 1'b0, OP_NONE, 5'd0, 1'b0, S_PULLP, 6'd0);
    chk("osr_autopull", 32'(ifc.osr_autopull), 32'd1);

    // Four OUT 8 with thr=32: last one shifts and pops together.
    step("out8a", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHIFT, 6'd8);
    step("out8b", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHIFT, 6'd16);
    step("out8c", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHIFT, 6'd24);
    step("out8d", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHPOP, 6'd0);

    // Fill to 32 without autopull, then OUT stalls on an empty FIFO.
    ifc.autopull = 1'b0;
    step("out32", 1'b1, OP_OUT, 5'd0, 1'b0, S_SHIFT, 6'd32);
    ifc.autopull = 1'b1;
    step("stout1", 1'b1, OP_OUT, 5'd8, 1'b1, S_STALL, 6'd32);
    chk("state_stall_out", 32'(ifc.state), 32'(S_STALL_OUT));
    step("stout2", 1'b1, OP_OUT, 5'd8, 1'b1, S_STALL, 6'd32);
    step("stout3", 1'b1, OP_OUT, 5'd8, 1'b1, S_STALL, 6'd32);
    step("refill", 1'b1, OP_OUT, 5'd8, 1'b0, S_REFILL, 6'd0);
    step("shift5", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHIFT, 6'd8);
    chk("stall_cycles_out", 32'(ifc.stall_cycles), 32'd4);
    chk("state_after_out", 32'(ifc.state), 32'(S_IDLE));

    // Blocking PULL on an empty FIFO, then serviced.
    ifc.autopull = 1'b0;
    ifc.pull_block = 1'b1;
    step("bpull1", 1'b1, OP_PULL, 5'd0, 1'b1, S_STALL, 6'd8);
    step("bpull2", 1'b1, OP_PULL, 5'd0, 1'b1, S_STALL, 6'd8);
    chk("state_stall_pull", 32'(ifc.state), 32'(S_STALL_PULL));
    step("bpull3", 1'b1, OP_PULL, 5'd0, 1'b0, S_PULLP, 6'd0);
    chk("stall_cycles_pull", 32'(ifc.stall_cycles), 32'd6);

    // Non-blocking PULL on an empty FIFO loads X instead.
    ifc.pull_block = 1'b0;
    step("out5", 1'b1, OP_OUT, 5'd5, 1'b0, S_SHIFT, 6'd5);
    step("nbpull", 1'b1, OP_PULL, 5'd0, 1'b1, S_MOVX, 6'd0);

    // PULL IfEmpty below and at the threshold.
    ifc.pull_thresh = 5'd16;
    ifc.pull_ifempty = 1'b1;
    step("out4", 1'b1, OP_OUT, 5'd4, 1'b0, S_SHIFT, 6'd4);
    step("ife_noop", 1'b1, OP_PULL, 5'd0, 1'b0, S_NONE, 6'd4);
    step("out12", 1'b1, OP_OUT, 5'd12, 1'b0, S_SHIFT, 6'd16);
    step("ife_pull", 1'b1, OP_PULL, 5'd0, 1'b0, S_PULLP, 6'd0);
    ifc.pull_ifempty = 1'b0;
    ifc.pull_thresh = 5'd0;

    // Reset in the middle of an OUT stall abandons it without a pop.
    step("out32b", 1'b1, OP_OUT, 5'd0, 1'b0, S_SHIFT, 6'd32);
    ifc.autopull = 1'b1;
    step("stout_r", 1'b1, OP_OUT, 5'd8, 1'b1, S_STALL, 6'd32);
    chk("stall_cycles_pre_rst", 32'(ifc.stall_cycles), 32'd7);
    rst = 1'b1;
    step("rst_mid", 1'b1, OP_OUT, 5'd8, 1'b0, S_NONE, 6'd32);
    chk("rst_mid_state", 32'(ifc.state), 32'(S_IDLE));
    chk("rst_mid_stall_cycles", 32'(ifc.stall_cycles), 32'd0);
    rst = 1'b0;

    // Enable low: no strobes, nothing moves.
    ifc.en = 1'b0;
    step("en_off", 1'b1, OP_OUT, 5'd8, 1'b0, S_NONE, 6'd32);
    chk("en_off_stall_cycles", 32'(ifc.stall_cycles), 32'd0);
    ifc.en = 1'b1;

    // Saturating add at 32, then MOV to OSR suppresses background refill.
    ifc.autopull = 1'b0;
    step("sat", 1'b1, OP_OUT, 5'd8, 1'b0, S_SHIFT, 6'd32);
    ifc.autopull = 1'b1;
    step("mov", 1'b1, OP_MOV_OSR, 5'd0, 1'b0, S_NONE, 6'd0);
    chk("osr_autopull_empty", 32'(ifc.osr_autopull), 32'd1);
    step("idle_end", 1'b0, OP_NONE, 5'd0, 1'b1, S_NONE, 6'd0);
    chk("osr_autopull_gated", 32'(ifc.osr_autopull), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/osr_pull_controller.md
# osr_pull_controller

Sequencer for one state machine's output shift register (OSR) and its TX FIFO. It decodes the executing OUT / PULL / MOV-to-OSR operation, tracks the OSR shift count, and drives the OSR strobes and the FIFO pop. It enforces the autopull, blocking-PULL and IfEmpty rules and raises `stall` so the PC holds. It sits between the instruction decoder, the TX FIFO and the OSR datapath.

## Interface
- No parameters.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: clock-divider enable. When low, no strobes fire and all state holds.
- `instr_valid` in 1: an instruction is in execute this cycle.
- `op` in 2: `OP_NONE`=0, `OP_OUT`=1, `OP_PULL`=2, `OP_MOV_OSR`=3. `OP_NONE` also covers other opcodes.
- `pull_block` in 1: PULL is blocking.
- `pull_ifempty` in 1: PULL IfEmpty qualifier.
- `out_count` in 5: OUT bit count; 0 means 32.
- `autopull` in 1: autopull enable.
- `pull_thresh` in 5: pull threshold; 0 means 32.
- `fifo_empty` in 1: TX FIFO empty.
- `fifo_pop` out 1: pop the TX FIFO this cycle.
- `osr_pull` out 1: OSR PULL strobe.
- `osr_shift_en` out 1: OSR OUT strobe.
- `osr_autopull` out 1: qualified autopull sent to the OSR. Equals `autopull & ~fifo_empty`.
- `osr_mov_x` out 1: request to load X into the OSR (non-blocking PULL on an empty FIFO).
- `stall` out 1: hold the PC and re-present the same instruction.
- `osr_count` out 6: shadow shift count, range 0..32.
- `stall_cycles` out 16: saturating count of stalled cycles.

## Operation
**Derived values**
- `thr` = (`pull_thresh`==0) ? 32 : `pull_thresh`.
- `n` = (`out_count`==0) ? 32 : `out_count`.
- `sum` = min(`osr_count` + `n`, 32), computed 7 bits wide.

**Gating**
- Every rule below applies only when `en`=1.
- Every op-specific rule below applies only when `instr_valid`=1.

**OUT**
- If `autopull` and `osr_count` >= `thr` and FIFO non-empty:
  - assert `osr_pull`, `fifo_pop`, `stall`;
  - `osr_count` <- 0.
- If `autopull` and `osr_count` >= `thr` and FIFO empty:
  - assert `stall` only; state -> `S_STALL_OUT`.
- Otherwise:
  - assert `osr_shift_en`.
  - If `autopull` and `sum` >= `thr` and FIFO non-empty: assert `fifo_pop`; `osr_count` <- 0.
  - Else: `osr_count` <- `sum`.

**PULL**
- If `pull_ifempty` and `osr_count` < `thr`: no-op, no strobes.
- Else if FIFO non-empty: assert `osr_pull` and `fifo_pop`; `osr_count` <- 0.
- Else if `pull_block`: assert `stall`; state -> `S_STALL_PULL`.
- Else: assert `osr_mov_x`; `osr_count` <- 0.

**MOV_OSR**
- `osr_count` <- 0.
- No background refill this cycle.

**Background refill** (`op` = `OP_NONE`, or `instr_valid`=0)
- Condition: `autopull` and `osr_count` >= `thr` and FIFO non-empty.
- Action: assert `osr_pull` and `fifo_pop`; `osr_count` <- 0.

**State machine** (`S_IDLE`, `S_STALL_OUT`, `S_STALL_PULL`)
- Any stall state returns to `S_IDLE` on the cycle the re-presented instruction completes.
- Any stall state also returns to `S_IDLE` if `instr_valid` drops or `op` changes.
- State is informational: the rules above are re-evaluated every cycle from the current inputs.

**Stall counter**
- `stall_cycles` increments on every cycle with `stall`=1.
- It saturates at 0xFFFF and clears only on reset.

**Invariants**
- `osr_pull` and `osr_shift_en` are never both high.
- `fifo_pop` is never asserted when `fifo_empty`=1.

## Timing
- All strobes and `stall` are combinational (Mealy) from the inputs, `osr_count` and state. They are valid in the same cycle as the instruction, because the OSR registers on that edge.
- `osr_count`, state and `stall_cycles` update on the rising edge. `osr_count` matches the OSR's counter from the next cycle on.
- A FIFO that becomes non-empty while stalled is serviced in the first cycle `fifo_empty`=0. For OUT this is a refill plus a further stall cycle, with the shift in the cycle after.
- Reset values:
  - `osr_count`=32, state `S_IDLE`, `stall_cycles`=0;
  - all strobes 0 while `rst`=1.
- `rst` overrides every operation in the same cycle. Reset during a stall abandons it with no pop.

## Structure
- Package `pio_osr_pkg` holds:
  - `osr_op_t` enum;
  - `osr_ctl_state_t` enum;
  - `OSR_BITS`=32 and `OSR_CNT_W`=6.
- One natural sub-module: `osr_count_tracker`. It holds the registered shadow count, the 0->32 threshold/count decode, the saturating add and the compares against `thr`.

## Test plan
- Reset, then idle with `autopull`=1, `thr`=32, FIFO non-empty -> background pull next cycle: `fifo_pop`=1, `osr_pull`=1, `osr_count` 32->0.
- `osr_count`=0, `thr`=32, OUT `out_count`=8 four times, FIFO non-empty -> counts 8, 16, 24; the fourth OUT asserts `osr_shift_en`+`fifo_pop`, `osr_count`->0, never `stall`.
- `osr_count`=32, autopull on, FIFO empty for 3 cycles, then non-empty -> `stall`=1 for 4 cycles (3 empty + 1 refill), shift on the 5th; `stall_cycles`=4.
- Blocking PULL, FIFO empty 2 cycles -> `stall`=1 twice, state `S_STALL_PULL`, then a pop with `osr_count`=0. Non-blocking PULL on an empty FIFO -> `osr_mov_x`=1, no pop.
- PULL IfEmpty with `osr_count`=4, `thr`=16 -> no strobes; the same PULL with `osr_count`=16 -> pull and pop.
- `rst` asserted mid-`S_STALL_OUT` -> `S_IDLE`, `osr_count`=32, `stall_cycles`=0, no `fifo_pop`; `en`=0 with a pending OUT -> no strobes, counters unchanged.
